// File: rtl/weight_rom_stream_ctrl.sv
// weight_rom_stream_ctrl: streams ROM words 0..OUT_DEPTH-1 for num_passes passes through a credit-managed FIFO.
// Define WEIGHT_STREAM_CTRL_STATS_EN to add the stall_cycles counter port.
module weight_rom_stream_ctrl #(
    parameter int DATA_WIDTH  = 128,
    parameter int OUT_DEPTH   = 2304,
    parameter int ROM_LATENCY = 2,
    parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1,
    parameter int PASS_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_passes,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
`ifdef WEIGHT_STREAM_CTRL_STATS_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    localparam int FIFO_DEPTH = ROM_LATENCY + 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q;
    logic [PASS_WIDTH-1:0]   passes_q, pass_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    busy_q, done_q, ce_q;
    logic [ROM_LATENCY-1:0]  vld_q, vld_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_q, rd_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW1-1:0]          inflight;
    logic                    issue, push, pop, last_addr, last_pass, final_pop;

    assign busy           = busy_q;
    assign done           = done_q;
    assign rom_ce         = ce_q;
    assign rom_addr       = addr_q;
    assign data_out_valid = cnt_q != '0;
    assign data_out       = data_out_valid ? mem_q[rd_q] : '0;

    // Words in the ROM pipe still hold a FIFO credit until they land.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) inflight = inflight + CW1'(vld_q[i]);
    end

    always_comb begin
        vld_d = '0;
        vld_d[0] = issue;
        for (int i = 1; i < ROM_LATENCY; i++) vld_d[i] = vld_q[i-1];
    end

    assign issue     = state_q == RUN && (inflight + CW1'(cnt_q)) < CW1'(FIFO_DEPTH);
    assign push      = vld_q[ROM_LATENCY-1];
    assign pop       = data_out_valid && data_out_ready;
    assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
    assign last_addr = addr_q == ADDR_WIDTH'(OUT_DEPTH - 1);
    assign last_pass = pass_q == passes_q - PASS_WIDTH'(1);
    assign final_pop = state_q == DRAIN && pop && cnt_q == CW'(1) && vld_q == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            passes_q <= '0;
            pass_q   <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ce_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && num_passes != '0) begin
                        state_q  <= RUN;
                        passes_q <= num_passes;
                        pass_q   <= '0;
                        addr_q   <= '0;
                        busy_q   <= 1'b1;
                        ce_q     <= 1'b1;
                    end else if (start) begin
                        done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q <= last_addr ? '0 : addr_q + ADDR_WIDTH'(1);
                        pass_q <= last_addr ? pass_q + PASS_WIDTH'(1) : pass_q;
                        if (last_addr && last_pass) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (final_pop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ce_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            if (push) wr_q <= wr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_q + PW'(1);
            if (pop) rd_q <= rd_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= rom_q;
    end

`ifdef WEIGHT_STREAM_CTRL_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else if (state_q == IDLE && start) stall_q <= '0;
        else if (data_out_valid && !data_out_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_weight_rom_stream_ctrl.sv
// tb_weight_rom_stream_ctrl: directed checks of the weight ROM stream sequencer (OUT_DEPTH=8, ROM_LATENCY=2).
module tb_weight_rom_stream_ctrl;
    localparam int DW = 16;
    localparam int OD = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   num_passes = '0;
    logic          busy, done, rom_ce, data_out_valid;
    logic          data_out_ready = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q, data_out, p1, p2;
`ifdef WEIGHT_STREAM_CTRL_STATS_EN
    logic [31:0]   stall_cycles;
`endif
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    weight_rom_stream_ctrl #(
        .DATA_WIDTH(DW), .OUT_DEPTH(OD), .ROM_LATENCY(2), .PASS_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_passes(num_passes),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_ce(rom_ce),
        .rom_q(rom_q), .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
`ifdef WEIGHT_STREAM_CTRL_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    function automatic logic [DW-1:0] word(input int a);
        return 16'hA500 + 16'(a);
    endfunction

    // Two-stage ce-gated ROM pipe
    always @(posedge clk) begin
        if (rom_ce) begin
            p1 <= word(int'(rom_addr));
            p2 <= p1;
        end
    end
    assign rom_q = p2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int passes, input int low_pct, output int beats, output int dones,
                          output int span, output int max_out);
        int first, issued;
        logic [AW-1:0] prev;
        logic held;
        logic [DW-1:0] held_d;
        beats = 0; dones = 0; first = -1; span = 0; max_out = 0; issued = 0;
        prev = rom_addr; held = 1'b0; held_d = '0;
        start = 1'b1;
        num_passes = 16'(passes);
        for (int c = 0; c < 400 && dones == 0; c++) begin
            data_out_ready = $urandom_range(99) >= low_pct;
            if (c == 5) begin
                start = 1'b1;
                num_passes = 16'd7;
            end
            @(negedge clk);
            if (rom_addr != prev) issued++;
            prev = rom_addr;
            if (issued - beats > max_out) max_out = issued - beats;
            if (held) begin
                chk("stall_valid_held", data_out_valid, 1);
                chk("stall_data_held", data_out, held_d);
            end
            if (data_out_valid && data_out_ready) begin
                chk($sformatf("beat%0d", beats), data_out, word(beats % OD));
                if (first < 0) first = c;
                span = c - first + 1;
                beats++;
            end
            held = data_out_valid && !data_out_ready;
            held_d = data_out;
            if (done) dones++;
            next_cycle();
            start = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) dones++;
            chk("post_done_valid", data_out_valid, 0);
            next_cycle();
        end
    endtask

    initial begin
        int beats, dones, span, max_out, n;
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ce", rom_ce, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_valid", data_out_valid, 0);
        chk("rst_data", data_out, 0);
        next_cycle();

        // Single pass, exact cycle timing
        start = 1'b1;
        num_passes = 16'd1;
        data_out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            chk($sformatf("t1_busy_c%0d", c), busy, c >= 1 && c <= 11);
            chk($sformatf("t1_ce_c%0d", c), rom_ce, c >= 1 && c <= 11);
            if (c >= 1 && c <= 8) chk($sformatf("t1_addr_c%0d", c), rom_addr, c - 1);
            chk($sformatf("t1_valid_c%0d", c), data_out_valid, c >= 4 && c <= 11);
            if (c >= 4 && c <= 11) chk($sformatf("t1_data_c%0d", c), data_out, word(c - 4));
            chk($sformatf("t1_done_c%0d", c), done, c == 12);
            next_cycle();
            start = 1'b0;
        end

        // Three passes, full throughput
        stream(3, 0, beats, dones, span, max_out);
        chk("t2_beats", beats, 24);
        chk("t2_contiguous_span", span, 24);
        chk("t2_done_pulses", dones, 1);
        chk("t2_outstanding_le4", max_out <= 4, 1);

        // Two passes, random backpressure
        stream(2, 30, beats, dones, span, max_out);
        chk("t3_beats", beats, 16);
        chk("t3_done_pulses", dones, 1);
        chk("t3_outstanding_le4", max_out <= 4, 1);

        // Zero passes
        start = 1'b1;
        num_passes = 16'd0;
        data_out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t4_done_c%0d", c), done, c == 1);
            chk($sformatf("t4_busy_c%0d", c), busy, 0);
            chk($sformatf("t4_ce_c%0d", c), rom_ce, 0);
            chk($sformatf("t4_valid_c%0d", c), data_out_valid, 0);
            next_cycle();
            start = 1'b0;
        end

        // Async reset mid-run after three beats
        start = 1'b1;
        num_passes = 16'd2;
        n = 0;
        for (int c = 0; c < 100 && n < 3; c++) begin
            @(negedge clk);
            if (data_out_valid && data_out_ready) n++;
            next_cycle();
            start = 1'b0;
        end
        chk("t5_beats_before_rst", n, 3);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ce", rom_ce, 0);
        chk("t5_rst_addr", rom_addr, 0);
        chk("t5_rst_valid", data_out_valid, 0);
        chk("t5_rst_data", data_out, 0);
        chk("t5_rst_done", done, 0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        stream(1, 0, beats, dones, span, max_out);
        chk("t5_restart_beats", beats, 8);
        chk("t5_restart_done", dones, 1);

`ifdef WEIGHT_STREAM_CTRL_STATS_EN
        // Hold ready low for five valid cycles
        start = 1'b1;
        num_passes = 16'd1;
        data_out_ready = 1'b0;
        n = 0;
        dones = 0;
        for (int c = 0; c < 100 && dones == 0; c++) begin
            @(negedge clk);
            if (data_out_valid && !data_out_ready) n++;
            if (done) dones++;
            next_cycle();
            start = 1'b0;
            if (n == 5) data_out_ready = 1'b1;
        end
        chk("t6_done", dones, 1);
        chk("t6_stall_cycles", stall_cycles, 5);
        next_cycle();
        chk("t6_stall_hold", stall_cycles, 5);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk("t6_stall_cleared", stall_cycles, 0);
        repeat (20) next_cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
